// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, bubble insertion and a bubble counter.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

  state_t            stateReg, stateNext;
  logic [DATA_W-1:0] outDataReg, outDataNext;
  logic [CTRL_W-1:0] outCtrlReg, outCtrlNext;
  logic [CNT_W-1:0]  bubbleCntReg, bubbleCntNext;
  logic              accept, xfer;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skidDataReg, skidDataNext;
  logic [CTRL_W-1:0] skidCtrlReg, skidCtrlNext;
  logic              inReadyReg, inReadyNext;

  assign in_ready = inReadyReg & en & ~flush;
`else
  assign in_ready = (~out_valid | out_ready) & en & ~flush;
`endif

  // Output registers are kept at zero whenever the stage is empty, so bubbles need no extra masking.
  assign out_valid  = (stateReg != EMPTY);
  assign out_data   = outDataReg;
  assign out_ctrl   = outCtrlReg;
  assign bubble_cnt = bubbleCntReg;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    stateNext     = stateReg;
    outDataNext   = outDataReg;
    outCtrlNext   = outCtrlReg;
    bubbleCntNext = bubbleCntReg;
`ifdef PIPE_STAGE_SKID_EN
    skidDataNext  = skidDataReg;
    skidCtrlNext  = skidCtrlReg;
`endif
    if (en) begin
      if (!out_valid && !(&bubbleCntReg))
        bubbleCntNext = bubbleCntReg + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush) begin
        stateNext   = EMPTY;
        outDataNext = '0;
        outCtrlNext = '0;
`ifdef PIPE_STAGE_SKID_EN
        skidDataNext = '0;
        skidCtrlNext = '0;
`endif
      end else begin
        case (stateReg)
          EMPTY: begin
            if (accept) begin
              stateNext   = ONE;
              outDataNext = in_data;
              outCtrlNext = in_ctrl;
            end
          end
          ONE: begin
            if (accept && xfer) begin
              outDataNext = in_data;
              outCtrlNext = in_ctrl;
            end else if (xfer) begin
              stateNext   = EMPTY;
              outDataNext = '0;
              outCtrlNext = '0;
            end
`ifdef PIPE_STAGE_SKID_EN
            else if (accept) begin
              // Downstream stalled: the newer beat parks in the skid slot behind the older one.
              stateNext    = TWO;
              skidDataNext = in_data;
              skidCtrlNext = in_ctrl;
            end
`endif
          end
`ifdef PIPE_STAGE_SKID_EN
          TWO: begin
            if (xfer) begin
              stateNext    = ONE;
              outDataNext  = skidDataReg;
              outCtrlNext  = skidCtrlReg;
              skidDataNext = '0;
              skidCtrlNext = '0;
            end
          end
`endif
          default: begin
            stateNext   = EMPTY;
            outDataNext = '0;
            outCtrlNext = '0;
          end
        endcase
      end
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  assign inReadyNext = (stateNext != TWO);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= EMPTY;
      outDataReg   <= '0;
      outCtrlReg   <= '0;
      bubbleCntReg <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skidDataReg  <= '0;
      skidCtrlReg  <= '0;
      inReadyReg   <= 1'b1;
`endif
    end else begin
      stateReg     <= stateNext;
      outDataReg   <= outDataNext;
      outCtrlReg   <= outCtrlNext;
      bubbleCntReg <= bubbleCntNext;
`ifdef PIPE_STAGE_SKID_EN
      skidDataReg  <= skidDataNext;
      skidCtrlReg  <= skidCtrlNext;
      inReadyReg   <= inReadyNext;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (CNT_W=4 so saturation is reachable quickly).
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic [15:0] inCtrl;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [15:0] outCtrl;
  logic [3:0]  bubbleCnt;

  int vectors = 0;
  int miscompares = 0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_ctrl(outCtrl),
    .bubble_cnt(bubbleCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vector %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
  endtask

  task automatic chkOut(input string tag, input logic v, input logic [31:0] d,
                        input logic [15:0] c, input logic [3:0] b);
    chk({tag, ".valid"}, {31'd0, outValid}, {31'd0, v});
    chk({tag, ".data"}, outData, d);
    chk({tag, ".ctrl"}, {16'd0, outCtrl}, {16'd0, c});
    chk({tag, ".bubble"}, {28'd0, bubbleCnt}, {28'd0, b});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; inValid = 1'b0;
    inData = '0; inCtrl = '0; outReady = 1'b0;
    step();
    chkOut("reset", 1'b0, 32'h0, 16'h0, 4'h0);
    rst = 1'b0;
    #1 chk("reset.in_ready", {31'd0, inReady}, 32'd1);

    // Test 1: single beat, one-cycle latency
    inValid = 1'b1; inData = 32'h1234; inCtrl = 16'h0005; outReady = 1'b1;
    step();
    chkOut("t1.beat", 1'b1, 32'h1234, 16'h0005, 4'h1);
    inValid = 1'b0;
    step();
    chkOut("t1.drain", 1'b0, 32'h0, 16'h0, 4'h1);

    // Test 3: flush drops held 0xAA and incoming 0xBB
    inValid = 1'b1; inData = 32'hAA; inCtrl = 16'h0003; outReady = 1'b0;
    step();
    chkOut("t3.hold", 1'b1, 32'hAA, 16'h0003, 4'h2);
    flush = 1'b1; inData = 32'hBB; inCtrl = 16'h00FF;
    #1 chk("t3.flush_in_ready", {31'd0, inReady}, 32'd0);
    step();
    chkOut("t3.flushed", 1'b0, 32'h0, 16'h0, 4'h2);
    flush = 1'b0; inValid = 1'b0;
    step();
    chkOut("t3.no_bb", 1'b0, 32'h0, 16'h0, 4'h3);

    // Test 4: en=0 freezes everything
    inValid = 1'b1; inData = 32'h55; inCtrl = 16'h0007; outReady = 1'b0;
    step();
    chkOut("t4.hold", 1'b1, 32'h55, 16'h0007, 4'h4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inValid = i[0]; outReady = ~i[0]; flush = i[1]; inData = 32'h99;
      #1 chk("t4.in_ready", {31'd0, inReady}, 32'd0);
      step();
      chkOut("t4.frozen", 1'b1, 32'h55, 16'h0007, 4'h4);
    end
    en = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    step();
    chkOut("t4.drain", 1'b0, 32'h0, 16'h0, 4'h4);

`ifdef PIPE_STAGE_SKID_EN
    // Test 2: fill the skid slot, then drain in order
    outReady = 1'b0; inValid = 1'b1; inData = 32'h11; inCtrl = 16'h0001;
    step();
    chkOut("t2.a", 1'b1, 32'h11, 16'h0001, 4'h5);
    inData = 32'h22; inCtrl = 16'h0002;
    #1 chk("t2.in_ready_one", {31'd0, inReady}, 32'd1);
    step();
    inValid = 1'b0;
    #1 chk("t2.in_ready_two", {31'd0, inReady}, 32'd0);
    chkOut("t2.two", 1'b1, 32'h11, 16'h0001, 4'h5);
    outReady = 1'b1;
    step();
    chkOut("t2.b", 1'b1, 32'h22, 16'h0002, 4'h5);
    chk("t2.in_ready_after_a", {31'd0, inReady}, 32'd1);
    step();
    chkOut("t2.empty", 1'b0, 32'h0, 16'h0, 4'h5);

    // Test 6: reset in TWO with en=0
    outReady = 1'b0; inValid = 1'b1; inData = 32'h33; inCtrl = 16'h0003;
    step();
    inData = 32'h44; inCtrl = 16'h0004;
    step();
    inValid = 1'b0;
    chkOut("t6.pre", 1'b1, 32'h33, 16'h0003, 4'h6);
`else
    // Test 2 (combinational in_ready): backpressure then accept+transfer
    outReady = 1'b0; inValid = 1'b1; inData = 32'h11; inCtrl = 16'h0001;
    step();
    chkOut("t2.a", 1'b1, 32'h11, 16'h0001, 4'h5);
    inData = 32'h22; inCtrl = 16'h0002;
    #1 chk("t2.in_ready_stall", {31'd0, inReady}, 32'd0);
    step();
    chkOut("t2.stable", 1'b1, 32'h11, 16'h0001, 4'h5);
    outReady = 1'b1;
    #1 chk("t2.in_ready_go", {31'd0, inReady}, 32'd1);
    step();
    chkOut("t2.b", 1'b1, 32'h22, 16'h0002, 4'h5);
    inValid = 1'b0;
    step();
    chkOut("t2.empty", 1'b0, 32'h0, 16'h0, 4'h5);

    // Test 6: reset in ONE with en=0
    outReady = 1'b0; inValid = 1'b1; inData = 32'h33; inCtrl = 16'h0003;
    step();
    inValid = 1'b0;
    chkOut("t6.pre", 1'b1, 32'h33, 16'h0003, 4'h6);
`endif
    en = 1'b0; rst = 1'b1;
    step();
    chkOut("t6.reset", 1'b0, 32'h0, 16'h0, 4'h0);
    rst = 1'b0; en = 1'b1;
    #1 chk("t6.in_ready", {31'd0, inReady}, 32'd1);
    inValid = 1'b1; inData = 32'h66; inCtrl = 16'h0006; outReady = 1'b0;
    step();
    chkOut("t6.new", 1'b1, 32'h66, 16'h0006, 4'h1);
    inValid = 1'b0; outReady = 1'b1;
    step();
    chkOut("t6.skid_cleared", 1'b0, 32'h0, 16'h0, 4'h1);

    // Test 5: idle cycles saturate the 4-bit counter
    outReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 12) chk("t5.count14", {28'd0, bubbleCnt}, 32'd14);
    end
    chk("t5.saturated", {28'd0, bubbleCnt}, 32'hF);
    step();
    chk("t5.holding", {28'd0, bubbleCnt}, 32'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5.reset", {28'd0, bubbleCnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (operands, immediates, PCs).
REQ-002 SHALL have parameter CTRL_W, default 16: width of the control payload (write enables, ALU op, mux selects).
REQ-003 SHALL have parameter CNT_W, default 16: width of the bubble counter.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: global CPU enable; 0 freezes all state.
REQ-007 SHALL have port flush, input, 1: squash all held and incoming beats.
REQ-008 SHALL have port in_valid, input, 1: upstream beat present.
REQ-009 SHALL have port in_ready, output, 1: stage accepts a beat this cycle.
REQ-010 SHALL have port in_data, input, DATA_W: upstream datapath payload.
REQ-011 SHALL have port in_ctrl, input, CTRL_W: upstream control payload.
REQ-012 SHALL have port out_valid, output, 1: downstream beat present.
REQ-013 SHALL have port out_ready, input, 1: downstream consumes the beat.
REQ-014 SHALL have port out_data, output, DATA_W: downstream datapath payload.
REQ-015 SHALL have port out_ctrl, output, CTRL_W: downstream control payload.
REQ-016 SHALL have port bubble_cnt, output, CNT_W: count of enabled cycles with out_valid=0.

Function
REQ-017 Accept SHALL occur when in_valid & in_ready; transfer SHALL occur when out_valid & out_ready.
REQ-018 Latency SHALL be exactly 1 cycle: a beat accepted at edge N appears on out_* after edge N when the stage was empty.
REQ-019 Storage SHALL be an occupancy state machine: EMPTY, ONE, TWO (TWO only with the skid buffer; see REQ-031).
REQ-020 EMPTY SHALL go to ONE on accept; ONE SHALL stay ONE on accept+transfer, go to EMPTY on transfer only, and go to TWO on accept without transfer; TWO SHALL go to ONE on transfer.
REQ-021 Order SHALL be FIFO: the older beat is always on out_*; in TWO the newer beat waits in the skid slot.
REQ-022 When out_valid=0, out_ctrl SHALL be all zeros (bubble), so that no write enable or branch reaches the next stage.
REQ-023 When out_valid=0, out_data SHALL be all zeros.
REQ-024 While out_valid=1 and out_ready=0, out_data/out_ctrl SHALL stay stable.
REQ-025 Priority SHALL be rst > !en > flush > normal operation.
REQ-026 When en=0, all state SHALL hold, in_ready SHALL be 0, and bubble_cnt SHALL not count.
REQ-027 When en=1 and flush=1, the state SHALL go to EMPTY, all storage SHALL clear to zero, in_ready SHALL be 0, and any presented beat SHALL be dropped.
REQ-028 When en=1, bubble_cnt SHALL increment by 1 on each edge where out_valid=0, saturating at all-ones with no wrap.
REQ-029 A flush cycle SHALL itself count as a bubble when out_valid=0 before that edge.

Reset
REQ-030 On rst at a clock edge, the following SHALL hold regardless of en: state EMPTY, out_valid=0, out_data=0, out_ctrl=0, skid slot=0, and bubble_cnt=0.
REQ-030a On the cycle after rst, in_ready SHALL be 1 if en=1 and flush=0.

Configuration
REQ-031 With macro PIPE_STAGE_SKID_EN defined, the two-entry skid buffer SHALL be built, and in_ready SHALL be registered: 1 iff state is not TWO (gated by en & !flush).
REQ-031a With the macro undefined, only EMPTY and ONE SHALL exist, and in_ready SHALL be combinational: !out_valid | out_ready (gated by en & !flush).
REQ-032 Both builds SHALL give identical beat ordering, latency and bubble_cnt for any stimulus that never fills the skid slot.

Verification
REQ-033 Test 1: reset, then en=1 with in_valid=1, in_data=0x1234, in_ctrl=0x0005, out_ready=1. Expect out_valid=1, out_data=0x1234, out_ctrl=0x0005 one cycle later, and bubble_cnt=1.
REQ-034 Test 2 (SKID_EN): out_ready=0, then send beats A=0x11 and B=0x22. Expect state TWO and in_ready=0. Then set out_ready=1. Expect A, then B, on consecutive cycles, and in_ready=1 after A leaves.
REQ-035 Test 3: with state ONE holding 0xAA, assert flush together with in_valid=1 carrying 0xBB. Expect out_valid=0, out_ctrl=0, out_data=0 next cycle, and 0xBB never appearing.
REQ-036 Test 4: with state ONE holding 0x55, set en=0 for 5 cycles while toggling in_valid, out_ready and flush. Expect outputs unchanged, bubble_cnt unchanged and in_ready=0 throughout.
REQ-037 Test 5 (CNT_W=4): keep idle for 20 enabled cycles. Expect bubble_cnt=0xF and holding; then rst gives bubble_cnt=0.
REQ-038 Test 6: assert rst mid-stream with state TWO and en=0. Expect EMPTY, all outputs zero and bubble_cnt=0 after the edge.
